// File: rtl/sr_grant_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : sr_grant_arbiter
// Purpose  : Round-robin arbiter for one shared resource among N requesters.
//            It drives one-cycle set/clear strobes into an external bank of
//            N SR flip-flops, one ownership flag per requester. At most one
//            flag is set at a time, and set and clear never assert for the
//            same bit in the same cycle. The optional hold timeout bounds how
//            long an owner keeps the grant.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk      in   1        system clock, rising edge
//   reset    in   1        asynchronous active-high reset
//   req      in   N        level request per requester
//   rel      in   N        release pulse; only rel[owner] is honoured
//   gnt      out  N        one-hot registered grant
//   owner    out  OWNER_W  current owner index, valid while busy
//   busy     out  1        resource currently granted
//   set_s    out  N        one-cycle set strobe to the SR bank
//   set_r    out  N        one-cycle clear strobe to the SR bank
//   timeout  out  1        one-cycle pulse on forced release
// Build option
//   SRARB_TIMEOUT_EN  defined  : hold counter present, forced release after
//                                MAX_HOLD cycles, timeout pulses
//                     undefined: no hold counter, timeout tied low
// ============================================================================
module sr_grant_arbiter #(
  parameter int N        = 4,
  parameter int MAX_HOLD = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [N-1:0]         req,
  input  logic [N-1:0]         rel,
  output logic [N-1:0]         gnt,
  output logic [$clog2(N)-1:0] owner,
  output logic                 busy,
  output logic [N-1:0]         set_s,
  output logic [N-1:0]         set_r,
  output logic                 timeout
);

  localparam int OWNER_W = $clog2(N);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_GRANT   = 2'd1,
    ST_RELEASE = 2'd2
  } state_t;

  state_t               r_state;
  logic [OWNER_W-1:0]   r_rr_ptr;

  // Round-robin pick: first set request starting just after the last owner.
  logic                 w_found;
  logic [OWNER_W-1:0]   w_pick;
  int                   w_idx;

  always_comb begin
    w_found = 1'b0;
    w_pick  = '0;
    w_idx   = 0;
    for (int i = 1; i <= N; i++) begin
      w_idx = (int'(r_rr_ptr) + i) % N;
      if (!w_found && req[w_idx]) begin
        w_found = 1'b1;
        w_pick  = OWNER_W'(w_idx);
      end
    end
  end

  // Voluntary release: owner pulses rel or drops its request. Both at once
  // still form a single release.
  logic w_vol_rel;
  assign w_vol_rel = rel[owner] | ~req[owner];

`ifdef SRARB_TIMEOUT_EN
  localparam int HOLD_W = $clog2(MAX_HOLD + 1);

  logic [HOLD_W-1:0] r_hold;
  logic              w_hold_max;
  assign w_hold_max = (r_hold == HOLD_W'(MAX_HOLD));

  // Hold counter: 1 on the first granted cycle, counts every granted cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_hold <= '0;
    end else if (r_state == ST_IDLE && w_found) begin
      r_hold <= HOLD_W'(1);
    end else if (r_state == ST_GRANT && !w_vol_rel && !w_hold_max) begin
      r_hold <= r_hold + HOLD_W'(1);
    end else if (r_state != ST_GRANT) begin
      r_hold <= '0;
    end
  end
`else
  logic w_hold_max;
  assign w_hold_max = 1'b0;

  // Elaborates to nothing; keeps MAX_HOLD referenced when the counter is out.
  if (MAX_HOLD < 2) begin : g_max_hold_guard
  end
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= ST_IDLE;
      r_rr_ptr <= OWNER_W'(N - 1);
      gnt      <= '0;
      owner    <= '0;
      busy     <= 1'b0;
      set_s    <= '0;
      set_r    <= '0;
      timeout  <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          set_r   <= '0;
          timeout <= 1'b0;
          if (w_found) begin
            r_state       <= ST_GRANT;
            gnt           <= '0;
            gnt[w_pick]   <= 1'b1;
            set_s         <= '0;
            set_s[w_pick] <= 1'b1;
            owner         <= w_pick;
            busy          <= 1'b1;
          end
        end
        ST_GRANT: begin
          set_s <= '0;
          if (w_vol_rel || w_hold_max) begin
            r_state      <= ST_RELEASE;
            gnt          <= '0;
            busy         <= 1'b0;
            set_r        <= '0;
            set_r[owner] <= 1'b1;
            r_rr_ptr     <= owner;
            timeout      <= ~w_vol_rel & w_hold_max;
          end
        end
        ST_RELEASE: begin
          // Dead cycle: strobes drop, arbitration resumes from IDLE.
          r_state <= ST_IDLE;
          set_r   <= '0;
          timeout <= 1'b0;
        end
        default: begin
          r_state <= ST_IDLE;
          gnt     <= '0;
          busy    <= 1'b0;
          set_s   <= '0;
          set_r   <= '0;
          timeout <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_sr_grant_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_sr_grant_arbiter
// Purpose  : Directed self-checking bench for sr_grant_arbiter (N=4,
//            MAX_HOLD=16) with an external SR flag bank model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sr_grant_arbiter;

  localparam int N        = 4;
  localparam int MAX_HOLD = 16;

  logic         clk = 1'b0;
  logic         reset;
  logic [N-1:0] req;
  logic [N-1:0] rel;
  logic [N-1:0] gnt;
  logic [1:0]   owner;
  logic         busy;
  logic [N-1:0] set_s;
  logic [N-1:0] set_r;
  logic         timeout;

  int vectors = 0;
  int errors  = 0;

  sr_grant_arbiter #(.N(N), .MAX_HOLD(MAX_HOLD)) dut (
    .clk     (clk),
    .reset   (reset),
    .req     (req),
    .rel     (rel),
    .gnt     (gnt),
    .owner   (owner),
    .busy    (busy),
    .set_s   (set_s),
    .set_r   (set_r),
    .timeout (timeout)
  );

  always #5 clk = ~clk;

  // External SR flag bank and a one-cycle-delayed copy of gnt.
  logic [N-1:0] q;
  logic [N-1:0] gnt_d;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q     <= '0;
      gnt_d <= '0;
    end else begin
      q     <= (q | set_s) & ~set_r;
      gnt_d <= gnt;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [N-1:0] exp_bit;
    req   = '0;
    rel   = '0;
    reset = 1'b1;
    tick();
    tick();
    check("rst_gnt", 32'(gnt), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_owner", 32'(owner), 32'h0);
    check("rst_set_s", 32'(set_s), 32'h0);
    check("rst_set_r", 32'(set_r), 32'h0);
    check("rst_timeout", 32'(timeout), 32'h0);
    reset = 1'b0;
    tick();

    // Round robin with all requesting: owners 0,1,2,3,0.
    req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      exp_bit = 4'b0001 << (k % 4);
      tick();
      check("rr_gnt", 32'(gnt), 32'(exp_bit));
      check("rr_owner", 32'(owner), 32'(k % 4));
      check("rr_set_s", 32'(set_s), 32'(exp_bit));
      check("rr_busy", 32'(busy), 32'h1);
      tick();
      check("rr_set_s_drop", 32'(set_s), 32'h0);
      check("rr_gnt_hold", 32'(gnt), 32'(exp_bit));
      rel = exp_bit;
      if (k == 4) req = '0;
      tick();
      rel = '0;
      check("rr_rel_gnt", 32'(gnt), 32'h0);
      check("rr_rel_set_r", 32'(set_r), 32'(exp_bit));
      check("rr_rel_busy", 32'(busy), 32'h0);
      tick();
      check("rr_dead_gnt", 32'(gnt), 32'h0);
      check("rr_dead_set_r", 32'(set_r), 32'h0);
    end

    // Release by request drop: owner 1 drops, 0101 pending -> owner 2.
    req = 4'b0010;
    tick();
    check("drop_gnt1", 32'(gnt), 32'h2);
    req = 4'b0101;
    tick();
    check("drop_gnt", 32'(gnt), 32'h0);
    check("drop_set_r", 32'(set_r), 32'h2);
    check("drop_timeout", 32'(timeout), 32'h0);
    tick();
    tick();
    check("drop_next_gnt", 32'(gnt), 32'h4);
    check("drop_next_owner", 32'(owner), 32'h2);

    // Hand over to owner 0 and inject non-owner noise.
    req = 4'b0001;
    tick();
    check("hand_set_r", 32'(set_r), 32'h4);
    tick();
    tick();
    check("noise_gnt0", 32'(gnt), 32'h1);
    rel = 4'b0100;
    req = 4'b1001;
    tick();
    check("noise_gnt_a", 32'(gnt), 32'h1);
    check("noise_set_r_a", 32'(set_r), 32'h0);
    rel = '0;
    req = 4'b0001;
    tick();
    check("noise_gnt_b", 32'(gnt), 32'h1);
    check("noise_set_r_b", 32'(set_r), 32'h0);
    req = 4'b0000;
    tick();
    check("noise_end_set_r", 32'(set_r), 32'h1);
    tick();
    tick();

    // Hold timeout with a single persistent requester.
    req = 4'b1000;
    tick();
    check("to_gnt_first", 32'(gnt), 32'h8);
`ifdef SRARB_TIMEOUT_EN
    for (int c = 2; c <= MAX_HOLD; c++) begin
      tick();
      check("to_gnt_held", 32'(gnt), 32'h8);
      check("to_no_timeout", 32'(timeout), 32'h0);
    end
    tick();
    check("to_gnt_drop", 32'(gnt), 32'h0);
    check("to_set_r", 32'(set_r), 32'h8);
    check("to_pulse", 32'(timeout), 32'h1);
    tick();
    check("to_pulse_end", 32'(timeout), 32'h0);
    tick();
    check("to_regrant", 32'(gnt), 32'h8);
    check("to_regrant_set_s", 32'(set_s), 32'h8);
`else
    for (int c = 0; c < 2 * MAX_HOLD; c++) begin
      tick();
      check("to_gnt_held", 32'(gnt), 32'h8);
      check("to_no_timeout", 32'(timeout), 32'h0);
    end
`endif
    req = 4'b0000;
    tick();
    check("to_release", 32'(set_r), 32'h8);
    tick();
    tick();

    // Asynchronous reset in the middle of a grant to owner 2.
    req = 4'b0100;
    tick();
    check("mr_gnt", 32'(gnt), 32'h4);
    tick();
    #2;
    reset = 1'b1;
    #1;
    check("mr_gnt_clr", 32'(gnt), 32'h0);
    check("mr_busy_clr", 32'(busy), 32'h0);
    check("mr_set_r_clr", 32'(set_r), 32'h0);
    req = 4'b1111;
    tick();
    reset = 1'b0;
    tick();
    check("mr_regrant", 32'(gnt), 32'h1);
    check("mr_set_s", 32'(set_s), 32'h1);
    tick();
    check("mr_set_s_drop", 32'(set_s), 32'h0);

    // Random req/rel: SR safety invariants and SR bank tracking.
    for (int c = 0; c < 10000; c++) begin
      req = N'($urandom);
      rel = ($urandom_range(0, 3) == 0) ? N'($urandom) : '0;
      tick();
      check("rnd_s_and_r", 32'(set_s & set_r), 32'h0);
      check("rnd_onehot_gnt", 32'($onehot0(gnt)), 32'h1);
      check("rnd_onehot_s", 32'($onehot0(set_s)), 32'h1);
      check("rnd_onehot_r", 32'($onehot0(set_r)), 32'h1);
      check("rnd_bank_q", 32'(q), 32'(gnt_d));
      if (!busy) check("rnd_idle_gnt", 32'(gnt), 32'h0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
`default_nettype wire
